// File: rtl/axi4lite_pkg.sv
// Shared helpers for AXI4-Lite channel decoupling blocks: ceiling log2 and the
// derived widths of occupancy counters and storage indices.
package axi4lite_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    // Width of a counter that must hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return clog2(depth + 1);
    endfunction

    // Width of an index into a depth-entry store. It is at least one bit so
    // that a single-entry store still has a legal index signal.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/elastic_store.sv
// DEPTH x DATA_WIDTH flop array: one synchronous write port and one
// combinational read port. Entries reset to zero.
module elastic_store
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write the addressed entry when enabled.
    // NOTE: the array is reset on purpose so the head entry (and therefore the
    // downstream payload) reads zero out of reset; this ties the store to
    // flops, which is fine at these depths.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr_i == ADDR_W'(i)) begin
                    mem_q[i] <= wdata_i;
                end
            end
        end
    end

    // Read mux; indices beyond DEPTH-1 never occur and read as zero.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_i == ADDR_W'(i)) begin
                rdata_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/elastic_buffer.sv
// Valid/ready elastic buffer holding up to DEPTH beats in a circular flop
// store. Upstream ready is a flop and downstream valid/data decode from flops
// only, so neither side has a combinational path to the other.
module elastic_buffer
    import axi4lite_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int DEPTH             = 2,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          avalid,
    output logic                          aready,
    input  logic [DATA_WIDTH-1:0]         adata,
    output logic                          bvalid,
    input  logic                          bready,
    output logic [DATA_WIDTH-1:0]         bdata,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          almost_full
);

    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int ADDR_W = addr_width(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              aready_q, aready_d;
    logic              almost_full_q, almost_full_d;
    logic              push;
    logic              pop;

    // Pointers wrap explicitly so non-power-of-2 depths work.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for pointers, occupancy and the registered flags.
    // NOTE: every variable gets a default assignment first, so no path through
    // this block leaves one unassigned and no latch is inferred.
    always_comb begin
        push          = avalid & aready_q;
        pop           = (count_q != '0) & bready;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        aready_d      = (count_d != CNT_W'(DEPTH)) & ~flush;
        almost_full_d = ~flush & (count_d >= CNT_W'(ALMOST_FULL_LEVEL));
    end

    // State registers; reset empties the buffer and holds off upstream.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            aready_q      <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            aready_q      <= aready_d;
            almost_full_q <= almost_full_d;
        end
    end

    // A beat presented during a flush cycle is dropped, not stored.
    elastic_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .we_i    (push & ~flush),
        .waddr_i (wr_ptr_q),
        .wdata_i (adata),
        .raddr_i (rd_ptr_q),
        .rdata_o (bdata)
    );

    assign aready      = aready_q;
    assign bvalid      = (count_q != '0);
    assign count       = count_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_elastic_buffer.sv
// Directed bench for elastic_buffer: four instances (DEPTH 2, 4, 3, 1) share
// clock and reset; each scenario drives one instance while the others idle.
module tb_elastic_buffer;

    logic clk;
    logic reset;

    // DEPTH=2, 32-bit
    logic        flush2, avalid2, aready2, bvalid2, bready2, af2;
    logic [31:0] adata2, bdata2;
    logic [1:0]  count2;
    // DEPTH=4
    logic        flush4, avalid4, aready4, bvalid4, bready4, af4;
    logic [7:0]  adata4, bdata4;
    logic [2:0]  count4;
    // DEPTH=3
    logic        flush3, avalid3, aready3, bvalid3, bready3, af3;
    logic [7:0]  adata3, bdata3;
    logic [1:0]  count3;
    // DEPTH=1
    logic        flush1, avalid1, aready1, bvalid1, bready1, af1;
    logic [7:0]  adata1, bdata1;
    logic [0:0]  count1;

    int checks = 0;
    int errors = 0;

    elastic_buffer #(.DATA_WIDTH(32), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush2), .avalid(avalid2), .aready(aready2),
        .adata(adata2), .bvalid(bvalid2), .bready(bready2), .bdata(bdata2),
        .count(count2), .almost_full(af2));

    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush4), .avalid(avalid4), .aready(aready4),
        .adata(adata4), .bvalid(bvalid4), .bready(bready4), .bdata(bdata4),
        .count(count4), .almost_full(af4));

    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush3), .avalid(avalid3), .aready(aready3),
        .adata(adata3), .bvalid(bvalid3), .bready(bready3), .bdata(bdata3),
        .count(count3), .almost_full(af3));

    elastic_buffer #(.DATA_WIDTH(8), .DEPTH(1), .ALMOST_FULL_LEVEL(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush1), .avalid(avalid1), .aready(aready1),
        .adata(adata1), .bvalid(bvalid1), .bready(bready1), .bdata(bdata1),
        .count(count1), .almost_full(af1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  sb_q[$];
    logic [31:0] pat_a;
    logic [31:0] pat_b;
    logic        m_aready, m_push, m_pop;
    int          sent, recvd, cyc;

    initial begin
        reset = 1'b1;
        {flush2, avalid2, bready2} = '0; adata2 = '0;
        {flush4, avalid4, bready4} = '0; adata4 = '0;
        {flush3, avalid3, bready3} = '0; adata3 = '0;
        {flush1, avalid1, bready1} = '0; adata1 = '0;

        // ---------------- reset ----------------
        step();
        step();
        check("rst_aready2", aready2, 0);
        check("rst_bvalid2", bvalid2, 0);
        check("rst_count2",  count2,  0);
        check("rst_bdata2",  bdata2,  0);
        check("rst_af4",     af4,     0);
        check("rst_aready1", aready1, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_aready2_pre", aready2, 0);
        step();
        check("rel_aready2", aready2, 1);
        check("rel_bvalid2", bvalid2, 0);
        check("rel_count2",  count2,  0);
        check("rel_aready4", aready4, 1);
        check("rel_aready3", aready3, 1);
        check("rel_aready1", aready1, 1);
        check("rel_af1",     af1,     0);

        // ---------------- streaming, DEPTH=2 ----------------
        avalid2 = 1'b1;
        bready2 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            adata2 = 32'(k);
            step();
            check("str_bvalid", bvalid2, 1);
            check("str_bdata",  bdata2,  32'(k));
            check("str_count",  count2,  1);
            check("str_aready", aready2, 1);
        end
        avalid2 = 1'b0;
        step();
        check("str_drain_count",  count2,  0);
        check("str_drain_bvalid", bvalid2, 0);
        bready2 = 1'b0;

        // ---------------- backpressure fill/drain, DEPTH=4 ----------------
        avalid4 = 1'b1;
        bready4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adata4 = 8'hA0 + 8'(i);
            step();
            check("bp_fill_count",  count4,  32'(i + 1));
            check("bp_fill_af",     af4,     (i + 1 >= 3) ? 1 : 0);
            check("bp_fill_aready", aready4, (i < 3) ? 1 : 0);
            check("bp_fill_bdata",  bdata4,  8'hA0);
        end
        adata4 = 8'hA4;
        step();
        check("bp_full_count",  count4,  4);
        check("bp_full_aready", aready4, 0);
        check("bp_full_bdata",  bdata4,  8'hA0);
        bready4 = 1'b1;
        step();
        check("bp_pop1_count",  count4,  3);
        check("bp_pop1_aready", aready4, 1);
        check("bp_pop1_bdata",  bdata4,  8'hA1);
        check("bp_pop1_af",     af4,     1);
        step();
        check("bp_pp_count", count4, 3);
        check("bp_pp_bdata", bdata4, 8'hA2);
        adata4 = 8'hA5;
        step();
        check("bp_pp2_count", count4, 3);
        check("bp_pp2_bdata", bdata4, 8'hA3);
        avalid4 = 1'b0;
        step();
        check("bp_dr_count", count4, 2);
        check("bp_dr_bdata", bdata4, 8'hA4);
        check("bp_dr_af",    af4,    0);
        step();
        check("bp_dr2_count", count4, 1);
        check("bp_dr2_bdata", bdata4, 8'hA5);
        step();
        check("bp_dr3_count",  count4,  0);
        check("bp_dr3_bvalid", bvalid4, 0);
        bready4 = 1'b0;

        // ---------------- wrap with scoreboard, DEPTH=3 ----------------
        pat_a    = 32'b1011_0111_1101_1010_1110_1101_0111_1011;
        pat_b    = 32'b0110_0011_1011_0001_1101_0110_0111_1110;
        m_aready = 1'b1;
        sent     = 0;
        recvd    = 0;
        cyc      = 0;
        while ((sent < 10 || sb_q.size() != 0) && cyc < 80) begin
            avalid3 = (sent < 10) ? pat_a[cyc % 32] : 1'b0;
            adata3  = 8'h30 + 8'(sent);
            bready3 = pat_b[cyc % 32];
            check("wr_bvalid", bvalid3, (sb_q.size() != 0) ? 1 : 0);
            if (sb_q.size() != 0) check("wr_bdata", bdata3, sb_q[0]);
            check("wr_count",  count3,  sb_q.size());
            check("wr_aready", aready3, m_aready);
            m_push = avalid3 & m_aready;
            m_pop  = (sb_q.size() != 0) & bready3;
            step();
            if (m_pop) begin
                void'(sb_q.pop_front());
                recvd++;
            end
            if (m_push) begin
                sb_q.push_back(adata3);
                sent++;
            end
            m_aready = (sb_q.size() != 3);
            cyc++;
        end
        check("wr_received", recvd, 10);
        check("wr_final_count", count3, 0);
        avalid3 = 1'b0;
        bready3 = 1'b0;

        // ---------------- flush at count=3, DEPTH=4 ----------------
        avalid4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adata4 = 8'hB1 + 8'(i);
            step();
        end
        check("fl_pre_count",  count4,  3);
        check("fl_pre_aready", aready4, 1);
        flush4 = 1'b1;
        adata4 = 8'hEE;
        step();
        check("fl_count",  count4,  0);
        check("fl_bvalid", bvalid4, 0);
        check("fl_aready", aready4, 0);
        check("fl_af",     af4,     0);
        flush4 = 1'b0;
        adata4 = 8'h55;
        step();
        check("fl_rearm_aready", aready4, 1);
        check("fl_rearm_count",  count4,  0);
        check("fl_rearm_bvalid", bvalid4, 0);
        step();
        check("fl_first_bvalid", bvalid4, 1);
        check("fl_first_bdata",  bdata4,  8'h55);
        check("fl_first_count",  count4,  1);
        avalid4 = 1'b0;
        bready4 = 1'b1;
        step();
        check("fl_drain_count", count4, 0);
        bready4 = 1'b0;

        // ---------------- DEPTH=1 half throughput ----------------
        avalid1 = 1'b1;
        bready1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            adata1 = 8'hC0 + 8'(k);
            step();
            check("d1_full_aready", aready1, 0);
            check("d1_full_bvalid", bvalid1, 1);
            check("d1_full_bdata",  bdata1,  8'hC0 + 8'(k));
            check("d1_full_count",  count1,  1);
            step();
            check("d1_empty_aready", aready1, 1);
            check("d1_empty_bvalid", bvalid1, 0);
        end
        avalid1 = 1'b0;
        bready1 = 1'b0;

        // ---------------- asynchronous reset mid-operation ----------------
        avalid2 = 1'b1;
        adata2  = 32'h77;
        step();
        check("ar_pre_bvalid", bvalid2, 1);
        avalid2 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("ar_bvalid", bvalid2, 0);
        check("ar_aready", aready2, 0);
        check("ar_count",  count2,  0);
        check("ar_bdata",  bdata2,  0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("ar_rel_aready", aready2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elastic_buffer.md
Name: elastic_buffer

Overview:
Parametrised valid/ready elastic buffer: the next-generation skid buffer for AXI4-Lite channel decoupling in generated IP.
- Holds up to DEPTH beats in a circular flop store.
- aready comes from a flop, so no combinational path from bready to aready, and none from adata to bdata; both channel sides are fully timing-isolated.
- Adds occupancy count, an almost-full flag and a synchronous flush.
- Sits between an AXI4-Lite slave interface and the register-file logic, one instance per channel (AW, W, AR, B, R).

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
DEPTH, 2, number of beat entries (>=1; 1 gives half throughput, >=2 sustains 1 beat/cycle; non-power-of-2 allowed)
ALMOST_FULL_LEVEL, DEPTH-1, count threshold at or above which almost_full asserts (1..DEPTH)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all stored beats
avalid  in  1  upstream beat valid
aready  out  1  upstream ready (registered)
adata  in  DATA_WIDTH  upstream payload
bvalid  out  1  downstream beat valid
bready  in  1  downstream ready
bdata  out  DATA_WIDTH  downstream payload (head entry)
count  out  CNT_W  stored beats, CNT_W = clog2(DEPTH+1)
almost_full  out  1  count >= ALMOST_FULL_LEVEL

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0, storage = 0.
  - aready = 0, bvalid = 0, almost_full = 0, bdata = 0.
- First rising edge after reset release sets aready = 1.
- push = avalid & aready; pop = bvalid & bready.
- Ordinary cycle:
  - push writes adata to mem[wr_ptr] and advances wr_ptr.
  - pop advances rd_ptr.
  - count_next = count + push - pop.
- Pointers wrap DEPTH-1 -> 0 explicitly (no power-of-2 masking). ADDR_W = max(1, clog2(DEPTH)).
- aready is a flop: next value = (count_next != DEPTH) & ~flush. It depends only on state, never on the current bready/avalid.
- bvalid = (count != 0), decoded from flops only. bdata = mem[rd_ptr]. No bypass path.
- Latency: a beat accepted at edge N is visible on bvalid/bdata after edge N (cycle N+1).
- Simultaneous push and pop: legal at any count < DEPTH; count unchanged, both pointers advance.
- Full (count = DEPTH): aready = 0, so push is impossible. A pop at edge N raises aready after edge N; the upstream stall is one cycle.
- Empty (count = 0): bvalid = 0, and bready is ignored.
- avalid high while aready = 0: no write; upstream must hold adata stable (AXI rule). The block does not check this.
- Downstream must not see bdata change while bvalid & ~bready. This is guaranteed because rd_ptr moves only on pop.
- flush = 1 at edge N:
  - Takes priority over push and pop.
  - count = 0, pointers = 0, bvalid = 0 after edge N.
  - A beat presented with aready = 1 in that cycle is dropped.
  - aready = 0 for the cycle after the flush edge; it re-asserts on the next edge once flush is low.
  - Storage contents are not cleared.
- Reset mid-operation: all beats are lost immediately and aready/bvalid drop asynchronously.
- almost_full is registered, updated from count_next, and cleared by reset or flush.
- Throughput:
  - DEPTH >= 2 sustains 1 beat/clk with bready held high.
  - DEPTH = 1 alternates full/empty and gives 1 beat per 2 clk.

Decomposition:
- Shared package (axi4lite_pkg): clog2 function; CNT_W/ADDR_W derivation.
- One sub-module, elastic_store: DEPTH x DATA_WIDTH flop array with write enable, write index, async reset to 0, and combinational read index.
- Pointer, count and flag logic stays in elastic_buffer.

Test Plan:
- Reset release, DEPTH=2, avalid=0: aready 0 during reset, 1 one edge after release; bvalid=0, count=0 throughout.
- Streaming, DEPTH=2, bready=1, avalid=1, adata 0x1,0x2,0x3...: bvalid from cycle 1, bdata 0x1,0x2,0x3 one cycle behind, aready never drops, count stays 1.
- Backpressure fill/drain, DEPTH=4, bready=0, push 0xA0..0xA5:
  - Accepts 0xA0..0xA3; count=4, almost_full=1 from count 3; aready=0.
  - Then bready=1: outputs 0xA0..0xA5 in order, with aready rising the cycle after the first pop.
- Wrap, DEPTH=3: 10 random-gap push/pop beats with random bready; scoreboard order matches, and pointers wrap 2->0 with no loss or duplication.
- Flush at count=3, DEPTH=4, with avalid=1 in the flush cycle: count=0 and bvalid=0 next cycle; the concurrent beat does not appear; aready 0 for one cycle, then the next beat 0x55 is the first output.
- DEPTH=1, bready=1, continuous avalid: 1 beat per 2 clk, aready toggling, data order preserved.
